// File: rtl/rr_stream_mux_pkg.sv
// Shared types and helpers for the rr_stream_mux block and its arbiter.
package rr_stream_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_t;

    // Index width for n channels; never narrower than one bit.
    function automatic int calc_sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins, one-hot grant.
module rr_arbiter
    import rr_stream_mux_pkg::*;
#(
    parameter  int N  = 4,
    localparam int PW = calc_sel_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        grant = '0;
        for (int k = 0; k < N; k++) begin
            int  idx;
            idx = (int'(ptr) + k) % N;
            if (req[idx] && (grant == '0)) begin
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream mux with fixed or round-robin selection and a registered output.
// Optional packet locking on in_last is enabled by defining RR_STREAM_MUX_LOCK_EN.
module rr_stream_mux
    import rr_stream_mux_pkg::*;
#(
    parameter  int N_CH  = 4,
    parameter  int WIDTH = 8,
    localparam int SEL_W = calc_sel_w(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
`ifdef RR_STREAM_MUX_LOCK_EN
    input  logic [N_CH-1:0]       in_last,
`endif
    output logic [N_CH-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    input  logic                  out_ready
);

    logic             load_en;
    logic [SEL_W-1:0] ptr;
    logic [N_CH-1:0]  rr_grant;
    logic [N_CH-1:0]  fix_grant;
    logic [N_CH-1:0]  grant;
    logic             xfer;
    logic [SEL_W-1:0] xfer_ch;
    logic             last_beat;

`ifdef RR_STREAM_MUX_LOCK_EN
    logic             locked;
    logic [SEL_W-1:0] lock_ch;
    assign last_beat = |(grant & in_last);
`else
    assign last_beat = 1'b1;
`endif

    assign load_en = !out_valid || out_ready;

    rr_arbiter #(.N(N_CH)) u_arb (
        .req   (in_valid),
        .ptr   (ptr),
        .grant (rr_grant)
    );

    // Fixed mode looks only at the selected channel's valid.
    always_comb begin
        fix_grant = '0;
        if ((int'(sel) < N_CH) && in_valid[sel]) begin
            fix_grant[sel] = 1'b1;
        end
    end

    always_comb begin
        grant = '0;
        if (load_en) begin
            grant = (mode_t'(mode) == MODE_RR) ? rr_grant : fix_grant;
`ifdef RR_STREAM_MUX_LOCK_EN
            if (locked) begin
                grant          = '0;
                grant[lock_ch] = in_valid[lock_ch];
            end
`endif
        end
    end

    assign in_ready = grant;
    assign xfer     = |grant;

    always_comb begin
        xfer_ch = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) xfer_ch = SEL_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
`ifdef RR_STREAM_MUX_LOCK_EN
            locked    <= 1'b0;
            lock_ch   <= '0;
`endif
        end else begin
            if (load_en) begin
                out_valid <= xfer;
                if (xfer) begin
                    out_data <= in_data[int'(xfer_ch)*WIDTH +: WIDTH];
                    out_ch   <= xfer_ch;
                end
            end
            // Pointer moves only at the end of a packet (every beat when unlocked).
            if (xfer && (mode_t'(mode) == MODE_RR) && last_beat) begin
                ptr <= (xfer_ch == SEL_W'(N_CH - 1)) ? '0 : xfer_ch + 1'b1;
            end
`ifdef RR_STREAM_MUX_LOCK_EN
            if (xfer) begin
                locked  <= !last_beat;
                lock_ch <= xfer_ch;
            end
`endif
        end
    end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed table-driven bench for rr_stream_mux (N_CH=4, WIDTH=8), plus reset and lock sequences.
module tb_rr_stream_mux;

    localparam int N_CH  = 4;
    localparam int WIDTH = 8;
    localparam int SEL_W = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  mode;
    logic [SEL_W-1:0]      sel;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH*WIDTH-1:0] in_data;
`ifdef RR_STREAM_MUX_LOCK_EN
    logic [N_CH-1:0]       in_last;
`endif
    logic [N_CH-1:0]       in_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_ch;
    logic                  out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    rr_stream_mux #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
`ifdef RR_STREAM_MUX_LOCK_EN
        .in_last   (in_last),
`endif
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        ready;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [7:0]  exp_data;
        logic [1:0]  exp_ch;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic m, input logic [1:0] s, input logic [3:0] v,
                                input logic [31:0] d, input logic r, input logic [3:0] er,
                                input logic eov, input logic [7:0] ed, input logic [1:0] ec);
        vec_t x;
        x.mode = m; x.sel = s; x.valid = v; x.data = d; x.ready = r;
        x.exp_rdy = er; x.exp_ov = eov; x.exp_data = ed; x.exp_ch = ec;
        vecs.push_back(x);
    endfunction

    // Called on a negedge: drive, check in_ready, clock, check the output register.
    task automatic apply(input vec_t v, input int idx);
        mode = v.mode; sel = v.sel; in_valid = v.valid; in_data = v.data; out_ready = v.ready;
        #1;
        check($sformatf("vec%0d in_ready", idx), 32'(in_ready), 32'(v.exp_rdy));
        @(posedge clk);
        @(negedge clk);
        check($sformatf("vec%0d out_valid", idx), 32'(out_valid), 32'(v.exp_ov));
        if (v.exp_ov) begin
            check($sformatf("vec%0d out_data", idx), 32'(out_data), 32'(v.exp_data));
            check($sformatf("vec%0d out_ch", idx), 32'(out_ch), 32'(v.exp_ch));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    localparam logic [31:0] D  = 32'h0d0c0b0a;
    localparam logic [31:0] D2 = 32'h44332211;

    initial begin
        rst_n = 1'b0; mode = 1'b0; sel = '0; in_valid = '0; in_data = D; out_ready = 1'b1;
`ifdef RR_STREAM_MUX_LOCK_EN
        in_last = 4'b1111;
`endif
        @(negedge clk);
        do_reset();
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data", 32'(out_data), 32'd0);
        check("reset out_ch", 32'(out_ch), 32'd0);

        // Fixed mode
        add(0, 2, 4'hf, D, 1, 4'b0100, 1, 8'h0c, 2);
        add(0, 2, 4'hb, D, 1, 4'b0000, 0, 8'h00, 0);
        add(0, 3, 4'h8, D, 1, 4'b1000, 1, 8'h0d, 3);
        add(0, 0, 4'h1, D, 0, 4'b0000, 1, 8'h0d, 3);
        add(0, 0, 4'h1, D, 1, 4'b0001, 1, 8'h0a, 0);
        // Round-robin, all valid: 0,1,2,3,0,1
        add(1, 0, 4'hf, D2, 1, 4'b0001, 1, 8'h11, 0);
        add(1, 0, 4'hf, D2, 1, 4'b0010, 1, 8'h22, 1);
        add(1, 0, 4'hf, D2, 1, 4'b0100, 1, 8'h33, 2);
        add(1, 0, 4'hf, D2, 1, 4'b1000, 1, 8'h44, 3);
        add(1, 0, 4'hf, D2, 1, 4'b0001, 1, 8'h11, 0);
        add(1, 0, 4'hf, D2, 1, 4'b0010, 1, 8'h22, 1);
        // Round-robin, ch1 and ch3 only (ptr = 2): 3,1,3,1
        add(1, 0, 4'ha, D, 1, 4'b1000, 1, 8'h0d, 3);
        add(1, 0, 4'ha, D, 1, 4'b0010, 1, 8'h0b, 1);
        add(1, 0, 4'ha, D, 1, 4'b1000, 1, 8'h0d, 3);
        add(1, 0, 4'ha, D, 1, 4'b0010, 1, 8'h0b, 1);
        // Backpressure for 3 cycles, then release (ptr = 2)
        add(1, 0, 4'hf, D, 0, 4'b0000, 1, 8'h0b, 1);
        add(1, 0, 4'hf, D, 0, 4'b0000, 1, 8'h0b, 1);
        add(1, 0, 4'hf, D, 0, 4'b0000, 1, 8'h0b, 1);
        add(1, 0, 4'hf, D, 1, 4'b0100, 1, 8'h0c, 2);
        // Fixed beat leaves ptr at 3; RR resumes from there
        add(0, 1, 4'hf, D, 1, 4'b0010, 1, 8'h0b, 1);
        add(1, 0, 4'hf, D, 1, 4'b1000, 1, 8'h0d, 3);
        add(1, 0, 4'h0, D, 1, 4'b0000, 0, 8'h00, 0);

        foreach (vecs[i]) apply(vecs[i], i);

        // Reset mid-stream with out_valid = 1 and ptr = 2
        mode = 1'b1; in_valid = 4'hf; in_data = D; out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        check("pre-reset out_valid", 32'(out_valid), 32'd1);
        check("pre-reset out_ch", 32'(out_ch), 32'd1);
        out_ready = 1'b0;
        do_reset();
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst out_ch", 32'(out_ch), 32'd0);
        check("midrst out_data", 32'(out_data), 32'd0);
        out_ready = 1'b1;
        #1;
        check("post-reset in_ready", 32'(in_ready), 32'b0001);
        @(posedge clk); @(negedge clk);
        check("post-reset out_ch", 32'(out_ch), 32'd0);
        check("post-reset out_data", 32'(out_data), 32'h0a);

`ifdef RR_STREAM_MUX_LOCK_EN
        // Packet lock: ch1 sends 3 beats while ch2 waits; mode toggles ignored
        in_valid = '0;
        do_reset();
        in_valid = 4'b0110; out_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            in_data = {8'h0d, 8'h0c, 8'(8'h11 + b), 8'h0a};
            mode    = (b == 1) ? 1'b0 : 1'b1;
            sel     = 2'd2;
            in_last = (b == 2) ? 4'b0010 : 4'b0000;
            #1;
            check($sformatf("lock beat%0d in_ready", b), 32'(in_ready), (b < 3) ? 32'b0010 : 32'b0100);
            @(posedge clk); @(negedge clk);
            check($sformatf("lock beat%0d out_ch", b), 32'(out_ch), (b < 3) ? 32'd1 : 32'd2);
            check($sformatf("lock beat%0d out_data", b), 32'(out_data), (b < 3) ? 32'(8'h11 + b) : 32'h0c);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
